// File: rtl/sonar_stream_pkg.sv
// Shared types and constants for the sonar sample-stream path.
// Used by the channel arbiter and the downstream schedulers.
package sonar_stream_pkg;

    localparam int SONAR_NUM_CH = 8;
    localparam int SONAR_DATA_W = 24;
    localparam int SONAR_CH_W   = 3;

    typedef logic [SONAR_CH_W-1:0]          ch_idx_t;
    typedef logic signed [SONAR_DATA_W-1:0] sample_t;

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } arb_state_e;

    // Channel index reached by stepping off positions past base, modulo n.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_grant.
// Purely combinational so schedulers can register around it as needed.
module rr_pick
    import sonar_stream_pkg::*;
#(
    parameter int N  = SONAR_NUM_CH,
    parameter int IW = SONAR_CH_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] grant,
    output logic          grant_valid
);

    logic [2**IW-1:0] req_pad;
    int               idx;

    always_comb begin
        req_pad        = '0;
        req_pad[N-1:0] = req;
    end

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 1; k <= N; k++) begin
            idx = rr_wrap(int'(last_grant), k, N);
            if (!grant_valid && req_pad[IW'(idx)]) begin
                grant       = IW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_stream_arbiter.sv
// Merges per-channel sample streams into one channel-tagged stream,
// round-robin among enabled channels with optional packet locking.
module channel_stream_arbiter
    import sonar_stream_pkg::*;
#(
    parameter int NUM_CH         = SONAR_NUM_CH,
    parameter int DATA_W         = SONAR_DATA_W,
    parameter int CH_W           = SONAR_CH_W,
    parameter int LOCK_ON_PACKET = 0
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_aresetn,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    output logic [NUM_CH-1:0]        s_axis_tready,
    input  logic [NUM_CH-1:0]        s_axis_tlast,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [CH_W-1:0]          m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     locked
);

    localparam logic LOCK_EN = (LOCK_ON_PACKET != 0);

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
    logic [CH_W-1:0]   m_tuser_q, m_tuser_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              m_tlast_q, m_tlast_d;

    logic [NUM_CH-1:0] eligible;
    logic [CH_W-1:0]   grant;
    logic              grant_valid;
    logic              load_en;
    logic              accept;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;

    // A locked packet owns the arbiter regardless of ch_enable.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_q == ST_LOCKED) begin
                eligible[i] = s_axis_tvalid[i] & (lock_ch_q == CH_W'(i));
            end else begin
                eligible[i] = s_axis_tvalid[i] & ch_enable[i];
            end
        end
    end

    rr_pick #(
        .N  (NUM_CH),
        .IW (CH_W)
    ) u_rr_pick (
        .req         (eligible),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        load_en = !m_tvalid_q | m_axis_tready;
        accept  = load_en & grant_valid & s_axis_aresetn;
    end

    always_comb begin
        sel_data      = '0;
        sel_last      = 1'b0;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == CH_W'(i)) begin
                sel_data         = s_axis_tdata[i*DATA_W +: DATA_W];
                sel_last         = s_axis_tlast[i];
                s_axis_tready[i] = accept;
            end
        end
    end

    always_comb begin
        m_tdata_d    = m_tdata_q;
        m_tuser_d    = m_tuser_q;
        m_tlast_d    = m_tlast_q;
        m_tvalid_d   = m_tvalid_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            m_tvalid_d = accept;
            if (accept) begin
                m_tdata_d    = sel_data;
                m_tuser_d    = grant;
                m_tlast_d    = sel_last;
                last_grant_d = grant;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        unique case (state_q)
            ST_ARB: begin
                if (accept && LOCK_EN && !sel_last) begin
                    state_d   = ST_LOCKED;
                    lock_ch_d = grant;
                end
            end
            ST_LOCKED: begin
                if (accept && sel_last) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q      <= ST_ARB;
            lock_ch_q    <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            m_tdata_q    <= '0;
            m_tuser_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_ch_q    <= lock_ch_d;
            last_grant_q <= last_grant_d;
            m_tdata_q    <= m_tdata_d;
            m_tuser_q    <= m_tuser_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign locked        = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_channel_stream_arbiter.sv
// Self-checking bench: randomized per-channel sources, cycle model of
// the arbiter, and directed scenarios with literal expectations.
module tb_channel_stream_arbiter;

    localparam int N  = 8;
    localparam int DW = 24;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      ch_enable;
    logic [N*DW-1:0]   s_tdata;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N-1:0]      s_tlast;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [CW-1:0]     m_tuser;
    logic              m_tlast;
    logic              locked;

    channel_stream_arbiter #(
        .NUM_CH         (N),
        .DATA_W         (DW),
        .CH_W           (CW),
        .LOCK_ON_PACKET (1)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .ch_enable      (ch_enable),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tlast   (s_tlast),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tuser   (m_tuser),
        .m_axis_tlast   (m_tlast),
        .locked         (locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- sources ----------------
    bit [DW-1:0] sd [N];
    bit          sv [N];
    bit          sl [N];
    bit          hold [N];
    int          beat_idx [N];
    int          pkt_len [N];
    int          p_valid [N];
    int          fix_len [N];
    int          m_ready_pct;

    logic [CW-1:0] rec [$];
    int            fire_cyc [$];
    int            cyc;
    int            lock_cnt;
    logic [N-1:0]  ready_or;
    logic [N-1:0]  acc;

    task automatic apply_src();
        for (int i = 0; i < N; i++) begin
            s_tdata[i*DW +: DW] = sd[i];
            s_tvalid[i]         = sv[i] & !hold[i];
            s_tlast[i]          = sl[i];
        end
    endtask

    task automatic new_beat(input int i);
        if ($urandom_range(99) < p_valid[i]) begin
            sv[i] = 1'b1;
            sd[i] = DW'($urandom);
            if (beat_idx[i] == 0)
                pkt_len[i] = (fix_len[i] > 0) ? fix_len[i] : int'($urandom_range(1, 4));
            sl[i] = (beat_idx[i] == pkt_len[i] - 1);
            beat_idx[i] = sl[i] ? 0 : beat_idx[i] + 1;
        end else begin
            sv[i] = 1'b0;
        end
    endtask

    task automatic fill();
        for (int i = 0; i < N; i++)
            if (!sv[i] && !hold[i]) new_beat(i);
        apply_src();
    endtask

    task automatic cycle();
        @(negedge clk);
        acc = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            rec.push_back(m_tuser);
            fire_cyc.push_back(cyc);
        end
        if (locked) lock_cnt++;
        ready_or |= s_tready;
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (!hold[i] && (acc[i] || !sv[i])) new_beat(i);
        m_tready = ($urandom_range(99) < m_ready_pct);
        apply_src();
    endtask

    task automatic clear_rec();
        rec.delete();
        fire_cyc.delete();
        lock_cnt = 0;
        ready_or = '0;
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            sv[i] = 1'b0;
            hold[i] = 1'b0;
            beat_idx[i] = 0;
        end
        apply_src();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_tvalid", m_tvalid, 0);
        chk("reset_m_tdata", m_tdata, 0);
        chk("reset_m_tuser", m_tuser, 0);
        chk("reset_m_tlast", m_tlast, 0);
        chk("reset_locked", locked, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_mode(input logic [N-1:0] en, input int pv, input int fl, input int mr);
        ch_enable = en;
        for (int i = 0; i < N; i++) begin
            p_valid[i] = pv;
            fix_len[i] = fl;
        end
        m_ready_pct = mr;
        m_tready = (mr >= 100);
    endtask

    // ---------------- reference model ----------------
    bit          mdl_v, mdl_l, mdl_lk;
    bit [DW-1:0] mdl_d;
    bit [CW-1:0] mdl_u;
    int          mdl_lch, mdl_last;
    bit          nx_v, nx_l, nx_lk, found, ld, elig;
    bit [DW-1:0] nx_d;
    bit [CW-1:0] nx_u;
    int          nx_lch, nx_last, g, c;
    logic [N-1:0] exp_rdy;

    task automatic mdl_reset();
        mdl_v = 0; mdl_l = 0; mdl_lk = 0; mdl_d = '0; mdl_u = '0;
        mdl_lch = 0; mdl_last = N - 1;
    endtask

    initial begin
        mdl_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mdl_reset();
                chk("rst_m_tvalid", m_tvalid, 0);
                chk("rst_s_tready", s_tready, 0);
                chk("rst_locked", locked, 0);
            end else begin
                found = 0;
                g = 0;
                for (int k = 1; k <= N; k++) begin
                    c = (mdl_last + k) % N;
                    if (mdl_lk) elig = (c == mdl_lch) && s_tvalid[c[2:0]];
                    else elig = s_tvalid[c[2:0]] && ch_enable[c[2:0]];
                    if (!found && elig) begin
                        found = 1;
                        g = c;
                    end
                end
                ld = !mdl_v || m_tready;
                exp_rdy = (ld && found) ? (N'(1) << g) : '0;
                chk("m_tvalid", m_tvalid, mdl_v);
                if (mdl_v) begin
                    chk("m_tdata", m_tdata, mdl_d);
                    chk("m_tuser", m_tuser, mdl_u);
                    chk("m_tlast", m_tlast, mdl_l);
                end
                chk("locked", locked, mdl_lk);
                chk("s_tready", s_tready, exp_rdy);
                nx_v = mdl_v; nx_d = mdl_d; nx_u = mdl_u; nx_l = mdl_l;
                nx_lk = mdl_lk; nx_lch = mdl_lch; nx_last = mdl_last;
                if (ld) begin
                    nx_v = found;
                    if (found) begin
                        nx_d = DW'(s_tdata >> (g * DW));
                        nx_u = CW'(g);
                        nx_l = s_tlast[g[2:0]];
                        nx_last = g;
                        if (!mdl_lk && !nx_l) begin
                            nx_lk = 1;
                            nx_lch = g;
                        end else if (mdl_lk && nx_l) begin
                            nx_lk = 0;
                        end
                    end
                end
            end
            @(posedge clk);
            if (!rst_n) begin
                mdl_reset();
            end else begin
                mdl_v = nx_v; mdl_d = nx_d; mdl_u = nx_u; mdl_l = nx_l;
                mdl_lk = nx_lk; mdl_lch = nx_lch; mdl_last = nx_last;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    // ---------------- scenarios ----------------
    int i0;

    initial begin
        cyc = 0;
        ch_enable = '0;
        m_tready = 1'b0;
        set_mode('0, 0, 1, 100);
        clear_rec();
        for (int i = 0; i < N; i++) begin
            sd[i] = '0; sl[i] = 0; pkt_len[i] = 1;
        end

        // Plain round robin over channels 0..2
        reset_all();
        set_mode(8'h07, 0, 1, 100);
        for (int i = 0; i < 3; i++) p_valid[i] = 100;
        fill();
        clear_rec();
        for (int k = 0; k < 20 && rec.size() < 6; k++) cycle();
        chk("rr3_count", rec.size(), 6);
        if (rec.size() >= 6) begin
            for (int k = 0; k < 6; k++) chk($sformatf("rr3_tuser%0d", k), rec[k], k % 3);
            chk("rr3_back_to_back", fire_cyc[5] - fire_cyc[0], 5);
        end

        // Sparse enable mask: only 0 and 2 may win
        set_mode(8'h05, 100, 1, 100);
        fill();
        clear_rec();
        repeat (14) cycle();
        chk("mask_count_ok", rec.size() >= 12, 1);
        for (int k = 2; k + 1 < rec.size(); k++) begin
            chk("mask_in_set", (rec[k] == 0) || (rec[k] == 2), 1);
            chk("mask_alternate", rec[k] != rec[k+1], 1);
        end
        chk("mask_ready1_never", ready_or[1], 0);

        // Packet lock: ch0 4-beat packet, ch1 single beats
        reset_all();
        set_mode(8'h03, 0, 1, 100);
        p_valid[0] = 100; p_valid[1] = 100; fix_len[0] = 4;
        fill();
        clear_rec();
        for (int k = 0; k < 20 && rec.size() < 5; k++) cycle();
        chk("lock_count", rec.size(), 5);
        if (rec.size() >= 5) begin
            for (int k = 0; k < 4; k++) chk($sformatf("lock_tuser%0d", k), rec[k], 0);
            chk("lock_tuser4", rec[4], 1);
        end
        chk("lock_cycles", lock_cnt, 3);

        // Downstream stall with a beat pending
        set_mode(8'hFF, 80, 0, 100);
        repeat (20) cycle();
        m_ready_pct = 0;
        cycle();
        #1;
        chk("stall_pending", m_tvalid, 1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            #1;
            chk("stall_tready", s_tready, 0);
            chk("stall_valid", m_tvalid, 1);
        end
        m_ready_pct = 100;
        repeat (20) cycle();

        // Async reset in the middle of a locked packet
        set_mode(8'hFF, 100, 4, 100);
        i0 = 0;
        for (int k = 0; k < 20 && !locked; k++) begin
            cycle();
            i0++;
        end
        chk("areset_got_lock", locked, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_m_tvalid", m_tvalid, 0);
        chk("areset_m_tdata", m_tdata, 0);
        chk("areset_m_tuser", m_tuser, 0);
        chk("areset_m_tlast", m_tlast, 0);
        chk("areset_locked", locked, 0);
        chk("areset_s_tready", s_tready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("release_locked", locked, 0);
        chk("release_grant_ch0", s_tready, 8'h01);
        clear_rec();
        for (int k = 0; k < 10 && rec.size() < 1; k++) cycle();
        chk("release_first_tuser", (rec.size() > 0) ? rec[0] : 7, 0);

        // Locked channel 3 withdraws tvalid for three cycles
        reset_all();
        set_mode(8'h0F, 0, 1, 100);
        for (int i = 0; i < 4; i++) p_valid[i] = 100;
        fix_len[3] = 6;
        fill();
        i0 = 0;
        for (int k = 0; k < 20 && !(mdl_lk && mdl_lch == 3); k++) cycle();
        chk("gap_lock3", mdl_lk && (mdl_lch == 3), 1);
        hold[3] = 1'b1;
        apply_src();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cycle();
            #1;
            chk("gap_no_grant", s_tready, 0);
            chk("gap_locked", locked, 1);
        end
        hold[3] = 1'b0;
        apply_src();
        #1;
        chk("gap_resume_ch3", s_tready, 8'h08);

        // Long random run
        set_mode(8'hFF, 70, 0, 80);
        for (int blk = 0; blk < 60; blk++) begin
            ch_enable = N'($urandom);
            for (int i = 0; i < N; i++) p_valid[i] = $urandom_range(0, 100);
            m_ready_pct = $urandom_range(30, 100);
            repeat (50) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
